// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one op per transaction, one aligned doubleword bus access, lane-shifted/extended load result.
// Optional macro YSYX_22050039_LSU_MISALIGN_EN traps misaligned accesses with out_err instead of issuing them.
`timescale 1ns/1ps
module ysyx_22050039_lsu #(
   parameter int XLEN   = 64,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [XLEN-1:0]   in_base,
   input  logic [XLEN-1:0]   in_offset,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic              out_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [MASK_W-1:0] mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        op_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic              err_q;
   logic [XLEN-1:0]   addr_sum;
   logic [2:0]        lane_q;
   logic              misalign_trap;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_val;
   logic [MASK_W-1:0] size_mask;

   assign addr_sum = in_base + in_offset;
   assign lane_q   = addr_q[2:0];

`ifdef YSYX_22050039_LSU_MISALIGN_EN
   always_comb begin
      misalign_trap = 1'b0;
      case (in_op[1:0])
         2'd0: misalign_trap = 1'b0;
         2'd1: misalign_trap = addr_sum[0];
         2'd2: misalign_trap = |addr_sum[1:0];
         default: misalign_trap = |addr_sum[2:0];
      endcase
   end
`else
   assign misalign_trap = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = misalign_trap ? DONE : REQ;
         REQ:  if (mem_req_ready) state_nxt = WAIT;
         WAIT: if (mem_resp_valid) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bytes beyond the doubleword fall off the top of the shift and read as zero.
   always_comb begin
      shifted  = mem_resp_rdata >> {lane_q, 3'b000};
      load_val = shifted;
      case (op_q[1:0])
         2'd0: load_val = op_q[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                  : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         2'd1: load_val = op_q[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                  : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         2'd2: load_val = op_q[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                  : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      size_mask = '0;
      case (op_q[1:0])
         2'd0: size_mask = MASK_W'(8'h01);
         2'd1: size_mask = MASK_W'(8'h03);
         2'd2: size_mask = MASK_W'(8'h0F);
         default: size_mask = MASK_W'(8'hFF);
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            op_q    <= in_op;
            addr_q  <= addr_sum;
            wdata_q <= in_wdata;
            err_q   <= misalign_trap;
            rdata_q <= '0;
         end
         if (state == WAIT && mem_resp_valid) begin
            rdata_q <= op_q[3] ? '0 : load_val;
         end
      end
   end

   assign in_ready      = (state == IDLE) && rst;
   assign out_valid     = (state == DONE);
   assign out_rdata     = rdata_q;
   assign out_err       = err_q;
   assign mem_req_valid = (state == REQ);
   assign mem_req_we    = (state == REQ) && op_q[3];
   assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
   assign mem_req_wdata = op_q[3] ? (wdata_q << {lane_q, 3'b000}) : '0;
   assign mem_req_wmask = op_q[3] ? (size_mask << lane_q) : '0;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Randomized self-checking bench for ysyx_22050039_lsu: byte-level reference model plus directed literal cases.
`timescale 1ns/1ps
module tb_ysyx_22050039_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = '0;
   logic [63:0] in_base = '0;
   logic [63:0] in_offset = '0;
   logic [63:0] in_wdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_rdata;
   logic        out_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_resp_rdata = '0;

   int errors = 0;
   int checks = 0;
   int phase = 0;
   bit checkEn = 1'b0;

   logic [63:0] expReqAddr, expWdata, expRdata;
   logic [7:0]  expWmask;
   logic        expWe, expErr, skipBus;
   logic [63:0] gotReqAddr, gotWdata, gotRdata;
   logic [7:0]  gotWmask;
   logic        gotErr;

   ysyx_22050039_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model works byte by byte: which bytes move where, then extension.
   task automatic modelOp(input logic [3:0] op, input logic [63:0] base, input logic [63:0] off,
                          input logic [63:0] wd, input logic [63:0] rd);
      logic [63:0] addr;
      logic [63:0] val;
      int lane, nb;
      bit mis;
      addr = base + off;
      lane = int'(addr[2:0]);
      nb   = 1 << op[1:0];
      mis  = (lane % nb) != 0;
      expReqAddr = {addr[63:3], 3'b000};
      expWe = op[3];
      expWmask = '0;
      expWdata = '0;
      val = '0;
      for (int i = 0; i < 8; i++)
         if (lane + i < 8) expWdata[8*(lane+i) +: 8] = wd[8*i +: 8];
      for (int i = 0; i < nb; i++)
         if (lane + i < 8) begin
            if (op[3]) expWmask[lane+i] = 1'b1;
            else val[8*i +: 8] = rd[8*(lane+i) +: 8];
         end
      if (!op[3] && !op[2] && nb < 8 && val[8*nb-1])
         for (int j = 8*nb; j < 64; j++) val[j] = 1'b1;
      expRdata = op[3] ? 64'h0 : val;
`ifdef YSYX_22050039_LSU_MISALIGN_EN
      skipBus = mis;
      expErr  = mis;
      if (mis) expRdata = '0;
`else
      skipBus = 1'b0;
      expErr  = 1'b0;
      if (mis) skipBus = 1'b0;
`endif
   endtask

   // Protocol and data checker; phase tracks where the transaction should be.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("in_ready", 64'(in_ready), 64'(phase == 0));
         checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(phase == 1));
         checkOutput("out_valid", 64'(out_valid), 64'(phase == 3));
         if (phase == 1) begin
            checkOutput("req_addr", mem_req_addr, expReqAddr);
            checkOutput("req_we", 64'(mem_req_we), 64'(expWe));
            checkOutput("req_wmask", 64'(mem_req_wmask), 64'(expWmask));
            if (expWe) checkOutput("req_wdata", mem_req_wdata, expWdata);
         end
         if (phase == 3) begin
            checkOutput("out_rdata", out_rdata, expRdata);
            checkOutput("out_err", 64'(out_err), 64'(expErr));
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] op, input logic [63:0] base, input logic [63:0] off,
                                input logic [63:0] wd, input logic [63:0] rd,
                                input int reqStall, input int outStall);
      modelOp(op, base, off, wd, rd);
      in_valid = 1'b1; in_op = op; in_base = base; in_offset = off; in_wdata = wd;
      mem_req_ready = (reqStall == 0) && !skipBus;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op = 4'($urandom); in_base = {$urandom, $urandom};
      in_offset = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
      gotReqAddr = '0; gotWmask = '0; gotWdata = '0;
      if (skipBus) begin
         phase = 3;
      end else begin
         phase = 1;
         @(negedge clk);
         gotReqAddr = mem_req_addr; gotWmask = mem_req_wmask; gotWdata = mem_req_wdata;
         repeat (reqStall) @(negedge clk);
         mem_req_ready = 1'b1;
         @(posedge clk); #1;
         mem_req_ready = 1'b0;
         phase = 2;
         mem_resp_valid = 1'b1; mem_resp_rdata = rd;
         @(posedge clk); #1;
         mem_resp_valid = 1'b0; mem_resp_rdata = {$urandom, $urandom};
         phase = 3;
      end
      @(negedge clk);
      gotRdata = out_rdata; gotErr = out_err;
      repeat (outStall) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      phase = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [11:0] imm;
      #12;
      checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
      checkOutput("rst_req_valid", 64'(mem_req_valid), 64'h0);
      checkOutput("rst_req_addr", mem_req_addr, 64'h0);
      checkOutput("rst_out_rdata", out_rdata, 64'h0);
      @(negedge clk); rst = 1'b1; phase = 0;
      #1 checkEn = 1'b1;
      @(posedge clk); #1;

      applyStimulus(4'b0011, 64'h80000000, 64'h0, 64'h0, 64'h1122334455667788, 0, 0);
      checkOutput("t1_ld_rdata", gotRdata, 64'h1122334455667788);
      checkOutput("t1_ld_err", 64'(gotErr), 64'h0);
      applyStimulus(4'b0000, 64'h80000000, 64'h0, 64'h0, 64'h1122334455667788, 0, 0);
      checkOutput("t2_lb_rdata", gotRdata, 64'hFFFFFFFFFFFFFF88);
      applyStimulus(4'b0100, 64'h80000000, 64'h0, 64'h0, 64'h1122334455667788, 1, 0);
      checkOutput("t2_lbu_rdata", gotRdata, 64'h88);
      applyStimulus(4'b0000, 64'h80000000, 64'h7, 64'h0, 64'h1122334455667788, 0, 1);
      checkOutput("t2_lb7_rdata", gotRdata, 64'h11);
      applyStimulus(4'b1001, 64'h80000000, 64'h6, 64'hABCD, 64'h0, 0, 0);
      checkOutput("t3_sh_addr", gotReqAddr, 64'h80000000);
      checkOutput("t3_sh_wmask", 64'(gotWmask), 64'hC0);
      checkOutput("t3_sh_wdata", gotWdata, 64'hABCD000000000000);
      checkOutput("t3_sh_rdata", gotRdata, 64'h0);
      applyStimulus(4'b1011, 64'h80001000, 64'h8, 64'h0123456789ABCDEF, 64'h0, 3, 2);
      checkOutput("t4_sd_addr", gotReqAddr, 64'h80001008);
      checkOutput("t4_sd_wmask", 64'(gotWmask), 64'hFF);

      // Reset while waiting for the response; a late response must be ignored.
      modelOp(4'b0011, 64'h80000010, 64'h0, 64'h0, 64'h0);
      in_valid = 1'b1; in_op = 4'b0011; in_base = 64'h80000010; in_offset = '0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; phase = 1;
      @(posedge clk); #1 mem_req_ready = 1'b0; phase = 2;
      @(posedge clk); #2 checkEn = 1'b0; rst = 1'b0;
      #1;
      checkOutput("t5_in_ready", 64'(in_ready), 64'h0);
      checkOutput("t5_out_valid", 64'(out_valid), 64'h0);
      checkOutput("t5_req_valid", 64'(mem_req_valid), 64'h0);
      checkOutput("t5_req_we", 64'(mem_req_we), 64'h0);
      checkOutput("t5_req_addr", mem_req_addr, 64'h0);
      checkOutput("t5_req_wmask", 64'(mem_req_wmask), 64'h0);
      checkOutput("t5_out_err", 64'(out_err), 64'h0);
      @(negedge clk); rst = 1'b1; phase = 0;
      #1 checkEn = 1'b1;
      @(posedge clk); #1 mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFEF00DCAFEF00D;
      @(posedge clk); #1 mem_resp_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t5_in_ready_after", 64'(in_ready), 64'h1);
      checkOutput("t5_out_rdata_after", out_rdata, 64'h0);
      @(posedge clk); #1;

      applyStimulus(4'b0010, 64'h80000000, 64'h6, 64'h0, 64'h1122334455667788, 0, 0);
`ifdef YSYX_22050039_LSU_MISALIGN_EN
      checkOutput("t6_lw_err", 64'(gotErr), 64'h1);
      checkOutput("t6_lw_rdata", gotRdata, 64'h0);
`else
      checkOutput("t6_lw_err", 64'(gotErr), 64'h0);
      checkOutput("t6_lw_addr", gotReqAddr, 64'h80000000);
      checkOutput("t6_lw_rdata", gotRdata, 64'h1122);
`endif

      for (int n = 0; n < 80; n++) begin
         imm = 12'($urandom);
         applyStimulus(4'($urandom), {32'h0, $urandom}, {{52{imm[11]}}, imm},
                       {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
